// File: rtl/eth_header_tx_pkg.sv
// Shared constants, state encoding and byte-select helper for the TX Ethernet header framer.
package eth_header_tx_pkg;

  localparam logic [15:0] ETH_ARP_TYPE  = 16'h0806;
  localparam logic [15:0] ETH_IP_TYPE   = 16'h0800;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    SFD,
    MAC_DST,
    MAC_SRC,
    ETH_TYPE,
    PAYLOAD,
    PAD,
    DRAIN
  } tx_hdr_state_t;

  // Byte idx of a MAC address, index 0 being the first byte on the wire ([47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_header_tx_if.sv
// Control, payload-in and framed-byte-out signals of the TX header framer.
interface eth_header_tx_if;

  logic        tx_start;
  logic        tx_type_arp;
  logic [47:0] mac_d_addr;
  logic [47:0] mac_s_addr;
  logic        busy;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_last;
  logic        payload_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        fcs_en;
  logic        frame_last;
  logic        err_oversize;

  modport master (
    input  tx_start, tx_type_arp, mac_d_addr, mac_s_addr,
    input  payload_data, payload_valid, payload_last, data_ready,
    output busy, payload_ready, data_out, data_valid, fcs_en, frame_last, err_oversize
  );

  modport slave (
    output tx_start, tx_type_arp, mac_d_addr, mac_s_addr,
    output payload_data, payload_valid, payload_last, data_ready,
    input  busy, payload_ready, data_out, data_valid, fcs_en, frame_last, err_oversize
  );

endinterface

// File: rtl/eth_header_tx.sv
// Ethernet TX framer: preamble, SFD, MACs and EtherType, then payload pass-through with
// zero padding to the minimum length and truncation at the maximum.
module eth_header_tx
  import eth_header_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500
) (
  input  logic            aclk,
  input  logic            areset,
  eth_header_tx_if.master bus
);

  localparam logic [2:0]  PRE_LAST = 3'(PREAMBLE_LEN - 1);
  localparam logic [10:0] MIN_C    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_C    = 11'(MAX_PAYLOAD);

  tx_hdr_state_t state_q, state_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [10:0]   pay_cnt_q, pay_cnt_d;
  logic [47:0]   mac_d_q, mac_d_d, mac_s_q, mac_s_d;
  logic          type_arp_q, type_arp_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fcs_en_q, fcs_en_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          can_load;
  logic [10:0]   pay_next;
  logic [15:0]   eth_type;

  assign can_load = !valid_q || bus.data_ready;
  assign pay_next = pay_cnt_q + 11'd1;
  assign eth_type = type_arp_q ? ETH_ARP_TYPE : ETH_IP_TYPE;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      pay_cnt_q  <= '0;
      mac_d_q    <= '0;
      mac_s_q    <= '0;
      type_arp_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fcs_en_q   <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      mac_d_q    <= mac_d_d;
      mac_s_q    <= mac_s_d;
      type_arp_q <= type_arp_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fcs_en_q   <= fcs_en_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    mac_d_d    = mac_d_q;
    mac_s_d    = mac_s_q;
    type_arp_d = type_arp_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fcs_en_d   = fcs_en_q;
    last_d     = last_q;
    err_d      = 1'b0;
    // Once the held byte is taken the register empties unless a state below refills it.
    if (can_load) begin
      valid_d  = 1'b0;
      fcs_en_d = 1'b0;
      last_d   = 1'b0;
    end
    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        pay_cnt_d  = '0;
        // The previous frame's last byte must be gone before a new frame is accepted.
        if (bus.tx_start && !valid_q) begin
          mac_d_d    = bus.mac_d_addr;
          mac_s_d    = bus.mac_s_addr;
          type_arp_d = bus.tx_type_arp;
          state_d    = PREAMBLE;
        end
      end
      PREAMBLE: if (can_load) begin
        data_d  = PREAMBLE_BYTE;
        valid_d = 1'b1;
        if (byte_cnt_q == PRE_LAST) begin
          byte_cnt_d = '0;
          state_d    = SFD;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
        end
      end
      SFD: if (can_load) begin
        data_d  = SFD_BYTE;
        valid_d = 1'b1;
        state_d = MAC_DST;
      end
      MAC_DST, MAC_SRC: if (can_load) begin
        data_d   = mac_byte((state_q == MAC_DST) ? mac_d_q : mac_s_q, byte_cnt_q);
        valid_d  = 1'b1;
        fcs_en_d = 1'b1;
        if (byte_cnt_q == 3'd5) begin
          byte_cnt_d = '0;
          state_d    = (state_q == MAC_DST) ? MAC_SRC : ETH_TYPE;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
        end
      end
      ETH_TYPE: if (can_load) begin
        data_d   = byte_cnt_q[0] ? eth_type[7:0] : eth_type[15:8];
        valid_d  = 1'b1;
        fcs_en_d = 1'b1;
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q[0]) begin
          byte_cnt_d = '0;
          state_d    = PAYLOAD;
        end
      end
      PAYLOAD: if (can_load && bus.payload_valid) begin
        data_d    = bus.payload_data;
        valid_d   = 1'b1;
        fcs_en_d  = 1'b1;
        pay_cnt_d = pay_next;
        if (bus.payload_last) begin
          if (pay_next >= MIN_C) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PAD;
          end
        end else if (pay_next == MAX_C) begin
          last_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      PAD: if (can_load) begin
        data_d    = 8'h00;
        valid_d   = 1'b1;
        fcs_en_d  = 1'b1;
        pay_cnt_d = pay_next;
        if (pay_next == MIN_C) begin
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: if (bus.payload_valid && bus.payload_last) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.data_out      = data_q;
    bus.data_valid    = valid_q;
    bus.fcs_en        = fcs_en_q;
    bus.frame_last    = last_q;
    bus.err_oversize  = err_q;
    bus.payload_ready = ((state_q == PAYLOAD) && can_load) || (state_q == DRAIN);
    // Still busy while the final byte waits in the output register.
    bus.busy          = (state_q != IDLE) || (valid_q && !bus.data_ready);
  end

endmodule

// File: tb/tb_eth_header_tx.sv
// Self-checking bench for eth_header_tx: directed frames with random payloads, random
// back-pressure, truncation, mid-frame reset and ignored start pulses.
module tb_eth_header_tx;

  logic clk = 1'b0;
  logic areset;

  eth_header_tx_if bus ();

  eth_header_tx #(
    .PREAMBLE_LEN(7),
    .MIN_PAYLOAD (46),
    .MAX_PAYLOAD (1500)
  ) dut (
    .aclk  (clk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] pay [0:1599];
  logic [7:0] stall_data;
  bit         stall_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: collects accepted beats and watches the hold rule under back-pressure.
  always @(negedge clk) begin
    if (areset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("hold_valid", 32'(bus.data_valid), 32'd1);
        check("hold_data", 32'(bus.data_out), 32'(stall_data));
      end
      stall_pend = bus.data_valid && !bus.data_ready;
      stall_data = bus.data_out;
      if (bus.data_valid && bus.data_ready) begin
        if (got_q.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        got_q.push_back({bus.fcs_en, bus.frame_last, bus.data_out});
      end
      if (bus.err_oversize) err_cnt++;
    end
  end

  // Expected wire image: {fcs_en, frame_last, byte} for every beat of the frame.
  task automatic build_exp(input bit arp, input logic [47:0] d, input logic [47:0] s,
                           input int len);
    int n;
    logic [9:0] tmp;
    exp_q.delete();
    repeat (7) exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hD5});
    for (int i = 0; i < 6; i++) exp_q.push_back({2'b10, d[47-8*i -: 8]});
    for (int i = 0; i < 6; i++) exp_q.push_back({2'b10, s[47-8*i -: 8]});
    exp_q.push_back({2'b10, 8'h08});
    exp_q.push_back({2'b10, arp ? 8'h06 : 8'h00});
    n = (len > 1500) ? 1500 : len;
    for (int i = 0; i < n; i++) exp_q.push_back({2'b10, pay[i]});
    for (int i = n; i < 46; i++) exp_q.push_back({2'b10, 8'h00});
    tmp = exp_q.pop_back();
    tmp[8] = 1'b1;
    exp_q.push_back(tmp);
  endtask

  task automatic send_frame(input bit arp, input logic [47:0] d, input logic [47:0] s,
                            input int len, input bit rnd, input bit starts, input string tag);
    int  idx;
    int  cycles;
    bit  fire;
    build_exp(arp, d, s, len);
    got_q.delete();
    err_cnt = 0;
    bus.tx_type_arp   = arp;
    bus.mac_d_addr    = d;
    bus.mac_s_addr    = s;
    bus.payload_valid = 1'b0;
    bus.data_ready    = 1'b1;
    bus.tx_start      = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_lat_edge1"}, 32'(bus.data_valid), 32'd0);
    idx = 0;
    cycles = 0;
    while (!(idx == len && !bus.busy) && cycles < 20000) begin
      bus.data_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.payload_valid = (idx < len) && (!rnd || $urandom_range(0, 3) != 0);
      bus.payload_data  = pay[(idx < len) ? idx : 0];
      bus.payload_last  = (idx == len - 1);
      bus.tx_start      = starts && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      fire = bus.payload_valid && bus.payload_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      cycles++;
      if (cycles == 1) check({tag, "_lat_edge2"}, 32'({bus.data_valid, bus.data_out}), 32'h155);
    end
    bus.tx_start      = 1'b0;
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
    bus.data_ready    = 1'b1;
    check({tag, "_timeout"}, 32'(cycles < 20000), 32'd1);
    check({tag, "_consumed"}, 32'(idx), 32'(len));
    repeat (30) @(posedge clk);
    #1;
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_err_pulses"}, 32'(err_cnt), (len > 1500) ? 32'd1 : 32'd0);
    if (!rnd) check({tag, "_no_bubbles"}, 32'(last_cyc - first_cyc + 1), 32'(exp_q.size()));
    $display("frame %s: len=%0d beats=%0d err_pulses=%0d", tag, len, got_q.size(), err_cnt);
  endtask

  initial begin
    logic [47:0] d2;
    logic [47:0] s2;
    logic [47:0] s5;
    bus.tx_start      = 1'b0;
    bus.tx_type_arp   = 1'b0;
    bus.mac_d_addr    = '0;
    bus.mac_s_addr    = '0;
    bus.payload_data  = '0;
    bus.payload_valid = 1'b0;
    bus.payload_last  = 1'b0;
    bus.data_ready    = 1'b1;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_fcs_en", 32'(bus.fcs_en), 32'd0);
    check("rst_last", 32'(bus.frame_last), 32'd0);
    check("rst_err", 32'(bus.err_oversize), 32'd0);
    check("rst_pready", 32'(bus.payload_ready), 32'd0);
    areset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 28; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 28, 1'b0, 1'b0, "arp28");

    for (int i = 0; i < 100; i++) pay[i] = 8'(i);
    d2 = {16'($urandom), 32'($urandom)};
    s2 = {16'($urandom), 32'($urandom)};
    send_frame(1'b0, d2, s2, 100, 1'b0, 1'b0, "ip100");
    send_frame(1'b0, d2, s2, 100, 1'b1, 1'b0, "ip100_bp");

    for (int i = 0; i < 1600; i++) pay[i] = 8'($urandom);
    send_frame(1'b0, d2, s2, 1600, 1'b0, 1'b0, "oversize");

    // Reset while the third source-MAC byte sits on the output.
    s5 = {16'($urandom), 32'($urandom)};
    bus.mac_d_addr  = d2;
    bus.mac_s_addr  = s5;
    bus.tx_type_arp = 1'b0;
    bus.tx_start    = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("midrst_src2", 32'({bus.fcs_en, bus.data_out}), 32'({1'b1, s5[31:24]}));
    areset = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(bus.data_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    areset = 1'b0;
    for (int i = 0; i < 60; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, d2, s5, 60, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 50; i++) pay[i] = 8'($urandom);
    send_frame(1'b0, d2, s2, 50, 1'b0, 1'b1, "start_pulses");

    for (int f = 0; f < 4; f++) begin
      int len;
      len = $urandom_range(1, 120);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      send_frame(1'($urandom_range(0, 1)), {16'($urandom), 32'($urandom)},
                 {16'($urandom), 32'($urandom)}, len, 1'b1, 1'b0, $sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
